// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: CPU priority by
// default, with a DMA starvation override, a DMA burst lock, and read-return routing.
module mem_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_din,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  input  logic              dma_lock,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       lock_r;
  owner_t     rd_owner;
  logic       starved;

  assign starved = (wait_cnt == MAX_WAIT_C);

  // Grants are gated by rst so nothing reaches the memory during a reset cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    dma_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rst) begin
      dma_gnt = dma_req & (lock_r | starved | ~cpu_req);
      cpu_gnt = cpu_req & ~dma_gnt;
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = '0;
    mem_din  = '0;
    if (dma_gnt) begin
      mem_en   = 1'b1;
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_din  = dma_din;
    end else if (cpu_gnt) begin
      mem_en   = 1'b1;
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wait_cnt <= 4'd0;
      lock_r   <= 1'b0;
      rd_owner <= OWN_NONE;
    end else begin
      if (!dma_req || dma_gnt)
        wait_cnt <= 4'd0;
      else if (!starved)
        wait_cnt <= wait_cnt + 4'd1;

      if (!dma_req || !dma_lock)
        lock_r <= 1'b0;
      else if (dma_gnt)
        lock_r <= 1'b1;

      if (dma_gnt && dma_we == 4'b0000)
        rd_owner <= OWN_DMA;
      else if (cpu_gnt && cpu_we == 4'b0000)
        rd_owner <= OWN_CPU;
      else
        rd_owner <= OWN_NONE;
    end
  end

  // A read granted just before a reset cycle is dropped: rvalid is masked by rst.
  assign cpu_rvalid = rst && (rd_owner == OWN_CPU);
  assign dma_rvalid = rst && (rd_owner == OWN_DMA);
  assign rdata      = (cpu_rvalid || dma_rvalid) ? mem_dout : 32'd0;

endmodule
